// File: rtl/gddr6_ca_pkg.sv
// gddr6_ca_pkg: command codes, CA field positions, request struct and encode helpers
package gddr6_ca_pkg;
  localparam logic [4:0] CMD_NOP1  = 5'd0;
  localparam logic [4:0] CMD_NOP2  = 5'd1;
  localparam logic [4:0] CMD_MRS   = 5'd2;
  localparam logic [4:0] CMD_ACT   = 5'd3;
  localparam logic [4:0] CMD_RD    = 5'd4;
  localparam logic [4:0] CMD_RDA   = 5'd5;
  localparam logic [4:0] CMD_WOM   = 5'd6;
  localparam logic [4:0] CMD_WOMA  = 5'd7;
  localparam logic [4:0] CMD_WDM   = 5'd8;
  localparam logic [4:0] CMD_WDMA  = 5'd9;
  localparam logic [4:0] CMD_WSM   = 5'd10;
  localparam logic [4:0] CMD_WSMA  = 5'd11;
  localparam logic [4:0] CMD_PREPB = 5'd12;
  localparam logic [4:0] CMD_PREAB = 5'd13;
  localparam logic [4:0] CMD_REFPB = 5'd14;
  localparam logic [4:0] CMD_REFAB = 5'd15;
  localparam logic [4:0] CMD_PDE   = 5'd16;
  localparam logic [4:0] CMD_PDX   = 5'd17;
  localparam logic [4:0] CMD_SRE   = 5'd18;
  localparam logic [4:0] CMD_SRX   = 5'd19;
  localparam logic [4:0] CMD_LDFF  = 5'd20;
  localparam logic [4:0] CMD_RDTR  = 5'd21;
  localparam logic [4:0] CMD_WRTR  = 5'd22;
  localparam logic [4:0] CMD_RFU   = 5'd23;
  localparam logic [4:0] CMD_CAT   = 5'd24;

  localparam logic [10:0] NOP_WORD = 11'h7FF;

  localparam int ACT_BIT   = 9;
  localparam int ROW14_BIT = 8;
  localparam int OP_HI     = 9;
  localparam int OP_LO     = 8;
  localparam int BANK_HI   = 7;
  localparam int BANK_LO   = 4;
  localparam int LOW_HI    = 3;
  localparam int LOW_LO    = 0;
  localparam int AP_BIT    = 4;
  localparam int COLH_HI   = 2;
  localparam int COLH_LO   = 0;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [3:0]  bank;
    logic [14:0] row;
    logic [6:0]  col;
  } cmd_req_t;

  function automatic logic is_col(input logic [4:0] c);
    return c == CMD_RD || c == CMD_RDA || c == CMD_WOM || c == CMD_WOMA;
  endfunction

  function automatic logic is_legal(input logic [4:0] c);
    return is_col(c) || c == CMD_ACT || c == CMD_PREPB || c == CMD_PREAB;
  endfunction

  // returns {rise, fall}; unused bits and CA[10] stay at 1
  function automatic logic [21:0] ca_encode(input cmd_req_t r);
    logic [10:0] ri;
    logic [10:0] fa;
    ri = NOP_WORD;
    fa = NOP_WORD;
    if (r.cmd == CMD_ACT) begin
      ri[ACT_BIT] = 1'b0;
      ri[ROW14_BIT] = r.row[14];
      ri[BANK_HI:BANK_LO] = r.bank;
      ri[LOW_HI:LOW_LO] = r.row[3:0];
      fa[9:0] = r.row[13:4];
    end else if (is_col(r.cmd)) begin
      ri[OP_HI:OP_LO] = 2'b11;
      fa[OP_HI:OP_LO] = (r.cmd == CMD_RD || r.cmd == CMD_RDA) ? 2'b01 : 2'b00;
      ri[BANK_HI:BANK_LO] = r.bank;
      ri[LOW_HI:LOW_LO] = r.col[3:0];
      fa[COLH_HI:COLH_LO] = r.col[6:4];
      fa[AP_BIT] = r.cmd == CMD_RDA || r.cmd == CMD_WOMA;
    end else if (r.cmd == CMD_PREPB || r.cmd == CMD_PREAB) begin
      ri[OP_HI:OP_LO] = 2'b10;
      fa[OP_HI:OP_LO] = 2'b00;
      ri[BANK_HI:BANK_LO] = r.bank;
      fa[AP_BIT] = r.cmd == CMD_PREAB;
    end
    return {ri, fa};
  endfunction

  // returns {cabi_n, word}; invert when the half carries 6 or more zeros
  function automatic logic [11:0] cabi_apply(input logic [10:0] w, input logic en);
    logic inv;
    inv = en && ($countones(w) <= 5);
    return {!inv, inv ? ~w : w};
  endfunction
endpackage

// File: rtl/gddr6_cmd_fifo.sv
// gddr6_cmd_fifo: request FIFO with registered ready and no full-bypass
import gddr6_ca_pkg::*;

module gddr6_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic     CLK_t,
  input  logic     RESET,
  input  logic     push,
  input  logic     pop,
  input  cmd_req_t din,
  output cmd_req_t dout,
  output logic     empty,
  output logic     ready
);
  localparam int AW = $clog2(DEPTH);
  cmd_req_t mem [DEPTH];
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic do_push, do_pop, full_n;
  assign empty = wp == rp;
  assign do_push = push && ready;
  assign do_pop = pop && !empty;
  assign wp_n = wp + (AW+1)'(do_push);
  assign rp_n = rp + (AW+1)'(do_pop);
  assign full_n = (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // pointer and ready update; ready reflects fullness after this edge
  always_ff @(posedge CLK_t or posedge RESET)
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      ready <= 1'b1;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      ready <= !full_n;
    end
  // storage write
  always_ff @(posedge CLK_t)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/gddr6_ca_encoder.sv
// gddr6_ca_encoder: buffers command requests, spaces column commands, drives CA words with CABI
import gddr6_ca_pkg::*;

module gddr6_ca_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TCCD_S = 2,
  parameter int TCCD_L = 4
) (
  input  logic        CLK_t,
  input  logic        RESET,
  input  logic        cabi_en,
  input  logic        bg_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cmd,
  input  logic [3:0]  req_bank,
  input  logic [14:0] req_row,
  input  logic [6:0]  req_col,
  output logic [10:0] ca_rise,
  output logic [10:0] ca_fall,
  output logic        cabi_rise_n,
  output logic        cabi_fall_n,
  output logic        cmd_issued,
  output logic        illegal_cmd
);
  localparam int CW = $clog2(TCCD_L + 1);
  localparam logic [CW-1:0] CNT_S = CW'(TCCD_S);
  localparam logic [CW-1:0] CNT_L = CW'(TCCD_L);
  cmd_req_t head;
  logic empty, col, legal, col_ok, issue, pop;
  logic [1:0] g;
  logic [CW-1:0] gap;
  logic [CW-1:0] grp [4];
  logic [21:0] enc;
  logic [11:0] cr, cf;

  gddr6_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK_t(CLK_t),
    .RESET(RESET),
    .push(req_valid),
    .pop(pop),
    .din({req_cmd, req_bank, req_row, req_col}),
    .dout(head),
    .empty(empty),
    .ready(req_ready)
  );

  assign g = head.bank[3:2];
  assign col = is_col(head.cmd);
  assign legal = is_legal(head.cmd);
  assign col_ok = gap >= CNT_S && (!bg_en || grp[g] >= CNT_L);
  assign issue = !empty && legal && (!col || col_ok);
  assign pop = issue || (!empty && !legal);
  assign enc = issue ? ca_encode(head) : {NOP_WORD, NOP_WORD};
  assign cr = cabi_apply(enc[21:11], cabi_en);
  assign cf = cabi_apply(enc[10:0], cabi_en);

  // registered CA outputs toward the DDR output mux
  always_ff @(posedge CLK_t or posedge RESET)
    if (RESET) begin
      ca_rise <= NOP_WORD;
      ca_fall <= NOP_WORD;
      cabi_rise_n <= 1'b1;
      cabi_fall_n <= 1'b1;
      cmd_issued <= 1'b0;
      illegal_cmd <= 1'b0;
    end else begin
      {cabi_rise_n, ca_rise} <= cr;
      {cabi_fall_n, ca_fall} <= cf;
      cmd_issued <= issue;
      illegal_cmd <= !empty && !legal;
    end

  // saturating cycles-since-column-issue counters, global and per bank group
  always_ff @(posedge CLK_t or posedge RESET)
    if (RESET) begin
      gap <= CNT_L;
      for (int i = 0; i < 4; i++) grp[i] <= CNT_L;
    end else begin
      gap <= (issue && col) ? CW'(1) : (gap == CNT_L ? gap : gap + CW'(1));
      for (int i = 0; i < 4; i++)
        grp[i] <= (issue && col && g == 2'(i)) ? CW'(1) : (grp[i] == CNT_L ? grp[i] : grp[i] + CW'(1));
    end
endmodule

// File: doc/gddr6_ca_encoder.md
# gddr6_ca_encoder

Command-side driver that feeds the GDDR6 CA bus of one channel. It accepts decoded command requests from the memory controller through a valid/ready handshake and buffers them in a small FIFO. It enforces tCCD_S/tCCD_L spacing between column commands, encodes each command into rising- and falling-half CA words per the JESD250D command truth table, and applies optional CABI inversion. Its outputs go to the DDR output mux in front of the pins, and they are what the channel checker decodes.

## Interface
- FIFO_DEPTH, 4: request FIFO entries (power of two, ≥2)
- TCCD_S, 2: min CLK_t cycles between any two column commands
- TCCD_L, 4: min CLK_t cycles between column commands to the same bank group when bank groups are enabled
- CLK_t  in  1  command clock; all logic on posedge
- RESET  in  1  asynchronous, active-high reset
- cabi_en  in  1  CABI enable (MR1 OP10); static, change only while FIFO empty
- bg_en  in  1  bank-group mode (MR3 OP10[1]); static, same rule
- req_valid  in  1  request valid
- req_ready  out  1  FIFO not full
- req_cmd  in  5  command code from shared package (NOP1..CAT numbering)
- req_bank  in  4  bank; group = bank[3:2]
- req_row  in  15  row address (ACT only)
- req_col  in  7  column address (column commands only)
- ca_rise  out  11  CA word for the rising half of CLK_t
- ca_fall  out  11  CA word for the falling half
- cabi_rise_n / cabi_fall_n  out  1 each  CABI_n per half; low = word inverted
- cmd_issued  out  1  one-cycle pulse; a non-NOP word is on ca_* this cycle
- illegal_cmd  out  1  one-cycle pulse; unsupported head entry dropped

## Operation
- Supported commands: ACT, RD, RDA, WOM, WOMA, PREpb, PREab. Any other code at the FIFO head is popped, drives illegal_cmd, and a NOP is issued that cycle.
- Encoding. Unused bits = 1, and CA[10] = 1 in both halves.
  - NOP: both halves 11'h7FF.
  - ACT: rise[9]=0, rise[8]=row[14], rise[7:4]=bank, rise[3:0]=row[3:0]; fall[9:0]=row[13:4].
  - RD/RDA: rise[9:8]=11, fall[9:8]=01. WOM/WOMA: rise[9:8]=11, fall[9:8]=00. For all four: rise[7:4]=bank, rise[3:0]=col[3:0], fall[2:0]=col[6:4], fall[4]=0 (RD/WOM) or 1 (RDA/WOMA).
  - PREpb/PREab: rise[9:8]=10, fall[9:8]=00, rise[7:4]=bank, fall[4]=0/1.
- CABI: with cabi_en=1, each half is evaluated independently. If the half contains ≥6 zeros in its 11 bits, all 11 bits are inverted and that half's cabi_*_n is driven 0; otherwise it is driven 1. With cabi_en=0, both cabi_*_n are 1.
- Scheduler: strict in-order, head-of-line blocking, one command per cycle.
  - Non-column commands issue as soon as they reach the head.
  - Column commands issue only when gap_cnt ≥ TCCD_S, and additionally grp_cnt[bank[3:2]] ≥ TCCD_L when bg_en=1.
  - gap_cnt and grp_cnt[0..3] are saturating cycles-since-last-column-issue counters, each width clog2(TCCD_L+1). A column issue resets gap_cnt and the issuing group's counter to 1 in the next cycle; otherwise counters increment to saturation.
- Cycles with no issue drive NOP.

## Timing
- Reset (async assert): ca_rise=ca_fall=11'h7FF, cabi_rise_n=cabi_fall_n=1, cmd_issued=illegal_cmd=0, FIFO empty, req_ready=1, all counters saturated at TCCD_L.
- Handshake: a transfer occurs on a posedge with req_valid & req_ready. req_ready is registered, equals !full, and has no full-bypass: a push into a full FIFO is not accepted even if a pop happens in the same cycle.
- Latency: a request accepted at edge N into an empty, unblocked FIFO appears on ca_* (registered) after edge N+1.
- Simultaneous push and pop on a non-empty, non-full FIFO is allowed; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
- Reset mid-operation flushes the FIFO, discards pending commands, and returns every output to its reset value within the same delta.

## Structure
- Package gddr6_ca_pkg holds:
  - the 5-bit command codes (NOP1..CAT)
  - field-position localparams for rise/fall encoding
  - the NOP word 11'h7FF
  - a cmd_req_t struct {cmd, bank, row, col}
- Sub-module gddr6_cmd_fifo: a parameterized synchronous FIFO of cmd_req_t, with the same clock and reset. Encoder, CABI and scheduler stay in the top.

## Test plan
- Reset → ca_rise=ca_fall=11'h7FF, cabi_*_n=1, req_ready=1, no pulses.
- cabi_en=0, RD bank 5 col 7'h2A → next cycle ca_rise=11'h75A, ca_fall=11'h5EA, cmd_issued=1 for one cycle.
- bg_en=1, RD bank 0, then RD bank 1, then RD bank 4, pushed back-to-back → issues at cycles t, t+4, t+6, NOPs between. Repeat with bg_en=0 → issues at t, t+2, t+4.
- cabi_en=1, ACT bank 0 row 0 → ca_rise=ca_fall=11'h3FF, cabi_rise_n=cabi_fall_n=0. Then NOP → 11'h7FF with both CABI_n=1.
- bg_en=1, push 6 RDs to bank 0 continuously → req_ready drops once 4 entries are held. Issue spacing is exactly 4 cycles, and all 6 issue in order.
- req_cmd=CAT (5'b11000) → illegal_cmd pulse, NOP on CA. Then assert RESET while 3 entries are queued → outputs at reset values immediately, and no queued command issues after deassertion.
